// File: rtl/gpio_pkg.sv
// rtl/gpio_pkg.sv - pin ownership constants and the shared owned-mask function
package gpio_pkg;

    localparam int PIN_UART_LO = 0;
    localparam int PIN_I2C_LO  = 2;
    localparam int PIN_SPI_LO  = 4;
    localparam int PIN_PWMB0   = 8;
    localparam int PIN_PWMA0   = 9;
    localparam int PIN_TMR_IN0 = 10;

    // Bit set = pin belongs to a peripheral; pins 15:11 always stay GPIO.
    function automatic logic [15:0] owned_mask(
        input logic en_pwm_outa0,
        input logic en_pwm_outb0,
        input logic en_tmr_in0,
        input logic en_spi,
        input logic en_i2c,
        input logic en_uart
    );
        logic [15:0] m;
        m = '0;
        m[PIN_UART_LO +: 2] = {2{en_uart}};
        m[PIN_I2C_LO +: 2]  = {2{en_i2c}};
        m[PIN_SPI_LO +: 4]  = {4{en_spi}};
        m[PIN_PWMB0]        = en_pwm_outb0;
        m[PIN_PWMA0]        = en_pwm_outa0;
        m[PIN_TMR_IN0]      = en_tmr_in0;
        return m;
    endfunction

endpackage

// File: rtl/gpio_debounce_bit.sv
// rtl/gpio_debounce_bit.sv - one pin's synchronizer, debounce counter and edge pulses
module gpio_debounce_bit #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic pin,
    output logic level,
    output logic rise,
    output logic fall
);
    import gpio_pkg::*;

    localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] chain;
    logic [CW-1:0]          cnt;
    logic                   stable;
    logic                   sync;
    logic                   accept;

    assign sync   = chain[SYNC_STAGES-1];
    // Accept is combinational so the status flag and the new level land on the same edge.
    assign accept = (sync != stable) && (cnt == CNT_MAX);
    assign rise   = accept & sync;
    assign fall   = accept & ~sync;
    assign level  = stable;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain  <= '0;
            cnt    <= '0;
            stable <= 1'b0;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], pin};
            if (sync == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                stable <= sync;
                cnt    <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/gpio_pins_sampler.sv
// rtl/gpio_pins_sampler.sv - pad input sampling, ownership split and edge interrupt status
module gpio_pins_sampler #(
    parameter int WIDTH           = 16,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] gpio_pins_in,
    input  logic             EN_PWM_OUTA0,
    input  logic             EN_PWM_OUTB0,
    input  logic             EN_TMR_IN0,
    input  logic             EN_SPI,
    input  logic             EN_I2C,
    input  logic             EN_UART,
    input  logic [WIDTH-1:0] rise_en,
    input  logic [WIDTH-1:0] fall_en,
    input  logic [WIDTH-1:0] irq_clr,
    output logic [WIDTH-1:0] gpio_data_out,
    output logic [WIDTH-1:0] periph_data_out,
    output logic [WIDTH-1:0] irq_status,
    output logic             irq
);
    import gpio_pkg::*;

    logic [WIDTH-1:0] level;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] owned;
    logic [WIDTH-1:0] set_evt;

    for (genvar i = 0; i < WIDTH; i++) begin : g_pin
        gpio_debounce_bit #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .clk  (clk),
            .rst  (rst),
            .pin  (gpio_pins_in[i]),
            .level(level[i]),
            .rise (rise[i]),
            .fall (fall[i])
        );
    end

    assign owned = owned_mask(EN_PWM_OUTA0, EN_PWM_OUTB0, EN_TMR_IN0,
                              EN_SPI, EN_I2C, EN_UART);

    // Ownership only steers the filtered level; filtering itself never restarts.
    assign gpio_data_out   = level & ~owned;
    assign periph_data_out = level & owned;

    // Events are seen on every pin; ownership only gates the irq line.
    assign set_evt = (rise & rise_en) | (fall & fall_en);
    assign irq     = |(irq_status & ~owned);

    // Set dominates clear when both hit the same bit on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_status <= '0;
        end else begin
            irq_status <= (irq_status & ~irq_clr) | set_evt;
        end
    end

endmodule

// File: tb/tb_gpio_pins_sampler.sv
// tb/tb_gpio_pins_sampler.sv - randomized and directed self-checking bench for gpio_pins_sampler
module tb_gpio_pins_sampler;

    localparam int SYNC = 2;
    localparam int DEB  = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] pins = '0;
    logic        en_pwm_outa0 = 0, en_pwm_outb0 = 0, en_tmr_in0 = 0;
    logic        en_spi = 0, en_i2c = 0, en_uart = 0;
    logic [15:0] rise_en = '0, fall_en = '0, irq_clr = '0;
    logic [15:0] gpio_data_out, periph_data_out, irq_status;
    logic        irq;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference: pad history delayed by the synchronizer, run length of differing samples.
    logic [15:0] m_stable;
    logic [15:0] m_status;
    int          m_run [16];
    logic [15:0] m_hist [$];

    gpio_pins_sampler dut (
        .clk            (clk),
        .rst            (rst),
        .gpio_pins_in   (pins),
        .EN_PWM_OUTA0   (en_pwm_outa0),
        .EN_PWM_OUTB0   (en_pwm_outb0),
        .EN_TMR_IN0     (en_tmr_in0),
        .EN_SPI         (en_spi),
        .EN_I2C         (en_i2c),
        .EN_UART        (en_uart),
        .rise_en        (rise_en),
        .fall_en        (fall_en),
        .irq_clr        (irq_clr),
        .gpio_data_out  (gpio_data_out),
        .periph_data_out(periph_data_out),
        .irq_status     (irq_status),
        .irq            (irq)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] own_of();
        logic [15:0] o;
        o = 16'h0000;
        if (en_uart)      o = o | 16'h0003;
        if (en_i2c)       o = o | 16'h000C;
        if (en_spi)       o = o | 16'h00F0;
        if (en_pwm_outb0) o = o | 16'h0100;
        if (en_pwm_outa0) o = o | 16'h0200;
        if (en_tmr_in0)   o = o | 16'h0400;
        return o;
    endfunction

    task automatic model_reset();
        m_stable = '0;
        m_status = '0;
        for (int i = 0; i < 16; i++) m_run[i] = 0;
        m_hist = {};
        for (int i = 0; i < SYNC; i++) m_hist.push_back(16'h0000);
    endtask

    task automatic model_edge();
        logic [15:0] s;
        logic [15:0] set;
        s = m_hist.pop_front();
        m_hist.push_back(pins);
        set = '0;
        for (int i = 0; i < 16; i++) begin
            if (s[i] != m_stable[i]) m_run[i] = m_run[i] + 1;
            else m_run[i] = 0;
            if (m_run[i] == DEB) begin
                m_stable[i] = s[i];
                m_run[i] = 0;
                if (s[i] ? rise_en[i] : fall_en[i]) set[i] = 1'b1;
            end
        end
        m_status = (m_status & ~irq_clr) | set;
    endtask

    task automatic step();
        @(posedge clk);
        if (rst) model_reset();
        else model_edge();
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        model_reset();
        pins = 16'($urandom);
        repeat (3) step();
        n_cmp++;
        if ({gpio_data_out, periph_data_out, irq_status, 15'd0, irq} !== 64'd0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %h/%h/%h/%b want all zero",
                     gpio_data_out, periph_data_out, irq_status, irq);
        end
        pins = 16'h0000;
        rst = 1'b0;
        repeat (8) step();
        n_cmp++;
        if (gpio_data_out !== 16'h0000 || irq_status !== 16'h0000) begin
            n_bad++;
            $display("FAIL reset_release: gpio %h status %h want 0000/0000", gpio_data_out, irq_status);
        end
    endtask

    task automatic test_latency();
        rise_en[12] = 1'b1;
        pins[12] = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            step();
            n_cmp++;
            if (gpio_data_out[12] !== (k == 6)) begin
                n_bad++;
                $display("FAIL latency_edge%0d: gpio[12]=%b want %b", k, gpio_data_out[12], k == 6);
            end
        end
        n_cmp++;
        if (irq_status[12] !== 1'b1 || irq !== 1'b1) begin
            n_bad++;
            $display("FAIL latency_irq: status[12]=%b irq=%b want 1/1", irq_status[12], irq);
        end
        irq_clr[12] = 1'b1;
        step();
        irq_clr = '0;
        n_cmp++;
        if (irq_status[12] !== 1'b0 || irq !== 1'b0) begin
            n_bad++;
            $display("FAIL latency_clear: status[12]=%b irq=%b want 0/0", irq_status[12], irq);
        end
        rise_en = '0;
    endtask

    task automatic test_glitch();
        logic saw_one;
        rise_en[13] = 1'b1;
        fall_en[13] = 1'b1;
        pins[13] = 1'b1;
        repeat (3) step();
        pins[13] = 1'b0;
        saw_one = 1'b0;
        repeat (10) begin
            step();
            saw_one = saw_one | gpio_data_out[13];
        end
        n_cmp++;
        if (saw_one !== 1'b0 || irq_status[13] !== 1'b0) begin
            n_bad++;
            $display("FAIL glitch_3: level_seen=%b status[13]=%b want 0/0", saw_one, irq_status[13]);
        end
        rise_en[13] = 1'b0;
        pins[13] = 1'b1;
        repeat (4) step();
        pins[13] = 1'b0;
        repeat (10) begin
            step();
            saw_one = saw_one | gpio_data_out[13];
        end
        n_cmp++;
        if (saw_one !== 1'b1 || gpio_data_out[13] !== 1'b0 || irq_status[13] !== 1'b1) begin
            n_bad++;
            $display("FAIL glitch_4: seen=%b final=%b status[13]=%b want 1/0/1",
                     saw_one, gpio_data_out[13], irq_status[13]);
        end
        fall_en = '0;
    endtask

    task automatic test_ownership();
        en_uart = 1'b1;
        pins[0] = 1'b1;
        repeat (7) step();
        n_cmp++;
        if (periph_data_out[0] !== 1'b1 || gpio_data_out[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL own_uart: periph[0]=%b gpio[0]=%b want 1/0", periph_data_out[0], gpio_data_out[0]);
        end
        en_uart = 1'b0;
        #1;
        n_cmp++;
        if (periph_data_out[0] !== 1'b0 || gpio_data_out[0] !== 1'b1) begin
            n_bad++;
            $display("FAIL own_swap: periph[0]=%b gpio[0]=%b want 0/1", periph_data_out[0], gpio_data_out[0]);
        end
    endtask

    task automatic test_irq_mask();
        irq_clr = 16'hFFFF;
        pins[3] = 1'b1;
        step();
        irq_clr = '0;
        repeat (7) step();
        fall_en[3] = 1'b1;
        en_i2c = 1'b1;
        pins[3] = 1'b0;
        repeat (6) step();
        n_cmp++;
        if (irq_status[3] !== 1'b1 || irq !== 1'b0) begin
            n_bad++;
            $display("FAIL mask_owned: status[3]=%b irq=%b want 1/0", irq_status[3], irq);
        end
        en_i2c = 1'b0;
        #1;
        n_cmp++;
        if (irq !== 1'b1) begin
            n_bad++;
            $display("FAIL mask_return: irq=%b want 1", irq);
        end
        irq_clr[3] = 1'b1;
        step();
        irq_clr = '0;
        n_cmp++;
        if (irq_status[3] !== 1'b0 || irq !== 1'b0) begin
            n_bad++;
            $display("FAIL mask_clear: status[3]=%b irq=%b want 0/0", irq_status[3], irq);
        end
        fall_en = '0;
    endtask

    task automatic test_back_to_back();
        rise_en[14] = 1'b1;
        pins[14] = 1'b1;
        repeat (5) step();
        irq_clr[14] = 1'b1;
        step();
        irq_clr = '0;
        n_cmp++;
        if (irq_status[14] !== 1'b1 || gpio_data_out[14] !== 1'b1) begin
            n_bad++;
            $display("FAIL set_beats_clear: status[14]=%b level=%b want 1/1", irq_status[14], gpio_data_out[14]);
        end
        rise_en = '0;
    endtask

    task automatic test_reset_abort();
        logic ev;
        rise_en[15] = 1'b1;
        fall_en[15] = 1'b1;
        pins[15] = 1'b1;
        repeat (SYNC + 2) step();
        rst = 1'b1;
        model_reset();
        #1;
        n_cmp++;
        if ({gpio_data_out, periph_data_out, irq_status, 15'd0, irq} !== 64'd0) begin
            n_bad++;
            $display("FAIL abort_outputs: got %h/%h/%h/%b want all zero",
                     gpio_data_out, periph_data_out, irq_status, irq);
        end
        repeat (2) step();
        pins[15] = 1'b0;
        rst = 1'b0;
        ev = 1'b0;
        repeat (10) begin
            step();
            ev = ev | irq_status[15] | gpio_data_out[15];
        end
        n_cmp++;
        if (ev !== 1'b0) begin
            n_bad++;
            $display("FAIL abort_no_event: pin15 activity=%b want 0", ev);
        end
        rise_en = '0;
        fall_en = '0;
    endtask

    task automatic test_random();
        logic [15:0] own;
        for (int c = 0; c < 600; c++) begin
            pins = pins ^ (16'($urandom) & 16'($urandom) & 16'($urandom));
            if ($urandom_range(0, 15) == 0)
                {en_pwm_outa0, en_pwm_outb0, en_tmr_in0, en_spi, en_i2c, en_uart} = 6'($urandom);
            if ($urandom_range(0, 31) == 0) begin
                rise_en = 16'($urandom);
                fall_en = 16'($urandom);
            end
            irq_clr = 16'($urandom) & 16'($urandom) & 16'($urandom) & 16'($urandom);
            step();
            own = own_of();
            n_cmp++;
            if (gpio_data_out !== (m_stable & ~own) || periph_data_out !== (m_stable & own) ||
                irq_status !== m_status || irq !== |(m_status & ~own)) begin
                n_bad++;
                $display("FAIL random_c%0d: gpio %h periph %h status %h irq %b want %h %h %h %b",
                         c, gpio_data_out, periph_data_out, irq_status, irq,
                         m_stable & ~own, m_stable & own, m_status, |(m_status & ~own));
            end
        end
        irq_clr = '0;
    endtask

    initial begin
        test_reset();
        test_latency();
        test_glitch();
        test_ownership();
        test_irq_mask();
        test_back_to_back();
        test_reset_abort();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
